// File: rtl/div16u8_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int N_DEFAULT = 8;

  // Width that holds the step count 0..2N.
  localparam int CNT_W = $clog2(2 * N_DEFAULT + 1);

  // Quotient reported when the divisor is zero.
  localparam logic [2*N_DEFAULT-1:0] DBZ_Q = '1;

endpackage

// File: rtl/div16u8_seq_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_restore_step
  import div_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N:0]   rem_in,
  input  logic         next_bit,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_out,
  output logic         q_bit
);

  logic [N:0] rem_shift;

  always_comb begin
    rem_shift = {rem_in[N-1:0], next_bit};
    // A set top bit means the shifted value already exceeds any N-bit divisor.
    q_bit     = rem_in[N] | (rem_shift >= {1'b0, divisor});
    rem_out   = q_bit ? (rem_shift - {1'b0, divisor}) : rem_shift;
  end

endmodule

// File: rtl/div16u8_seq.sv
// Sequential unsigned 2N/N restoring divider with ready/valid handshakes, one quotient bit per clock.
// Define DIV_APPROX_EN to skip the low APPROX_K quotient bits (truncated, approximate result).
module div16u8_seq
  import div_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int APPROX_K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Q,
  output logic [N-1:0]   R,
  output logic           dbz
);

`ifdef DIV_APPROX_EN
  localparam int SKIP = APPROX_K;
`else
  localparam int SKIP = 0 * APPROX_K;
`endif
  localparam int STEPS = 2 * N - SKIP;
  localparam int CW    = (N == N_DEFAULT) ? CNT_W : $clog2(2 * N + 1);
  localparam logic [2*N-1:0] DBZ_QUOT = {(2*N){DBZ_Q[0]}};

  state_t         state_reg;
  logic [2*N-1:0] dvd_reg;
  logic [N-1:0]   dvs_reg;
  logic [N:0]     rem_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2*N-1:0] q_reg;
  logic [N-1:0]   r_reg;
  logic           dbz_reg;
  logic           in_ready_reg;
  logic           out_valid_reg;

  logic [N:0]     rem_next;
  logic           q_bit;
  logic [2*N-1:0] dvd_next;

  div_restore_step #(.N(N)) u_step (
    .rem_in   (rem_reg),
    .next_bit (dvd_reg[2*N-1]),
    .divisor  (dvs_reg),
    .rem_out  (rem_next),
    .q_bit    (q_bit)
  );

  // Quotient bits enter the dividend register from the bottom as dividend bits leave the top.
  assign dvd_next = {dvd_reg[2*N-2:0], q_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      q_reg         <= '0;
      r_reg         <= '0;
      dbz_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            dvd_reg      <= A;
            dvs_reg      <= B;
            rem_reg      <= '0;
            cnt_reg      <= CW'(STEPS);
            in_ready_reg <= 1'b0;
            if (B == '0) begin
              q_reg         <= DBZ_QUOT;
              r_reg         <= A[N-1:0];
              dbz_reg       <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          dvd_reg <= dvd_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) begin
            // Shifting left drops any unprocessed dividend bits and zero-fills skipped quotient bits.
            q_reg         <= dvd_next << SKIP;
            r_reg         <= rem_next[N-1:0];
            dbz_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign Q         = q_reg;
  assign R         = r_reg;
  assign dbz       = dbz_reg;

endmodule

// File: tb/tb_div16u8_seq.sv
// Self-checking bench for div16u8_seq: directed cases plus random operands against an arithmetic model.
module tb_div16u8_seq;

`ifdef DIV_APPROX_EN
  localparam int K = 4;
`else
  localparam int K = 0;
`endif
  localparam int LAT = 16 - K;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        dbz;

  int checks   = 0;
  int failures = 0;

  div16u8_seq #(.N(8), .APPROX_K(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on the retained top bits of A.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r, output logic d);
    int unsigned aa;
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      d = 1'b1;
    end else begin
      aa = 32'(a) >> K;
      q  = 16'((aa / 32'(b)) << K);
      r  = 8'(aa % 32'(b));
      d  = 1'b0;
    end
  endfunction

  // Accepts one operand pair, waits for the result, checks it, optionally stalls the consumer.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    int          lat;
    model(a, b, eq, er, ed);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat <= 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), (b == 8'd0) ? 32'd0 : 32'(LAT));
    check("Q", 32'(Q), 32'(eq));
    check("R", 32'(R), 32'(er));
    check("dbz", 32'(dbz), 32'(ed));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_Q", 32'(Q), 32'(eq));
      check("hold_R", 32'(R), 32'(er));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("Q_kept", 32'(Q), 32'(eq));
    $display("op A=%0d B=%0d -> Q=%0d R=%0d dbz=%0d lat=%0d", a, b, Q, R, dbz, lat);
  endtask

  logic [15:0] ra;
  logic [7:0]  rb;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_Q", 32'(Q), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'd1000, 8'd7, 0);
    run_op(16'd65535, 8'd255, 0);
    run_op(16'd65535, 8'd1, 0);
    run_op(16'h1234, 8'd0, 0);
    run_op(16'd300, 8'd17, 5);

    // Abort an operation mid-calculation with an asynchronous reset.
    in_valid = 1'b1;
    A        = 16'd40000;
    B        = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_Q", 32'(Q), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("op reset mid-calc -> in_ready=%0d out_valid=%0d", in_ready, out_valid);
    run_op(16'd100, 8'd9, 0);

    for (int n = 0; n < 20; n++) begin
      ra = 16'($urandom);
      rb = (n % 7 == 3) ? 8'd0 : 8'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
